registers_bram_mt: RTL and testbench

- Parametrised successor to the per-thread BRAM register file of the sha512crypt CPU.
- Holds N_REGS registers of WIDTH bits for each of N_THREADS threads in one block RAM.
- Adds an N_DIN-way write-source mux, write-first forwarding on a same-address read, and qualified two-stage read outputs.
- Adds a hardware zero-sweep after reset and a per-thread clear request. The CPU uses the clear on thread (re)start instead of issuing software writes.

---
 rtl/registers_bram_mt.sv | 188 ++++++++++++++++++
 tb/tb_registers_bram_mt.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/registers_bram_mt.sv
// Per-thread register file in one block RAM with a write-source mux, write-first forwarding,
// a two-stage read pipeline, a zero-sweep after reset and a per-thread clear.
module registers_bram_mt #(
    parameter int WIDTH         = 16,
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0,
    parameter int N_REGS        = 16,
    parameter int REG_ADDR_MSB  = $clog2(N_REGS) - 1,
    parameter int N_DIN         = 4,
    parameter int SEL_MSB       = $clog2(N_DIN) - 1
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic [N_DIN*WIDTH-1:0]   din,
    input  logic [SEL_MSB:0]         din_select,
    input  logic                     wr_en,
    input  logic [N_THREADS_MSB:0]   wr_thread_num,
    input  logic [REG_ADDR_MSB:0]    wr_addr,
    input  logic                     rd_en0,
    input  logic                     rd_en1,
    input  logic [N_THREADS_MSB:0]   rd_thread_num,
    input  logic [REG_ADDR_MSB:0]    rd_addr,
    input  logic                     clear_req,
    input  logic [N_THREADS_MSB:0]   clear_thread,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     busy
);

    localparam int TH_W      = N_THREADS_MSB + 1;
    localparam int AD_W      = REG_ADDR_MSB + 1;
    localparam int ENTRY_W   = TH_W + AD_W;
    localparam int N_ENTRIES = N_THREADS * N_REGS;
    localparam int SEL_W     = SEL_MSB + 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ENTRY_W-1:0]  cnt_r;
    logic [ENTRY_W-1:0]  cnt_next_s;
    logic [TH_W-1:0]     clr_thread_r;
    logic [TH_W-1:0]     clr_thread_next_s;
    logic                busy_r;

    logic                mem_we_s;
    logic [ENTRY_W-1:0]  mem_waddr_s;
    logic [WIDTH-1:0]    mem_wdata_s;
    logic [WIDTH-1:0]    wr_data_s;
    logic                wr_acc_s;
    logic                idle_s;
    logic                rd_acc_s;
    logic                fwd_s;
    logic [ENTRY_W-1:0]  wr_idx_s;
    logic [ENTRY_W-1:0]  rd_idx_s;

    logic [WIDTH-1:0]    mem [0:N_ENTRIES-1];
    logic [WIDTH-1:0]    s1_data_r;
    logic                s1_valid_r;
    logic                s1_valid_next_s;
    logic [WIDTH-1:0]    dout_r;
    logic                dout_valid_r;

    assign wr_idx_s   = {wr_thread_num, wr_addr};
    assign rd_idx_s   = {rd_thread_num, rd_addr};
    assign idle_s     = (state_r == ST_IDLE);
    assign rd_acc_s   = rd_en0 & idle_s;
    assign fwd_s      = rd_acc_s & wr_acc_s & (wr_idx_s == rd_idx_s);
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;

    // Write-source mux; out-of-range selects fall back to source 0.
    always_comb begin
        wr_data_s = din[WIDTH-1:0];
        for (int k = 1; k < N_DIN; k++) begin
            wr_data_s = (din_select == SEL_W'(k)) ? din[k*WIDTH +: WIDTH] : wr_data_s;
        end
    end

    // Sweep FSM next-state and the single memory write port.
    always_comb begin
        state_next_s      = state_r;
        cnt_next_s        = cnt_r;
        clr_thread_next_s = clr_thread_r;
        mem_we_s          = 1'b0;
        mem_waddr_s       = wr_idx_s;
        mem_wdata_s       = wr_data_s;
        wr_acc_s          = 1'b0;
        case (state_r)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_r;
                mem_wdata_s = {WIDTH{1'b0}};
                if (cnt_r == ENTRY_W'(N_ENTRIES - 1)) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {ENTRY_W{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + ENTRY_W'(1);
                end
            end
            ST_IDLE: begin
                // A clear request takes priority over a write in the same cycle.
                if (clear_req) begin
                    state_next_s      = ST_CLEAR;
                    clr_thread_next_s = clear_thread;
                    cnt_next_s        = {ENTRY_W{1'b0}};
                end else if (wr_en) begin
                    mem_we_s = 1'b1;
                    wr_acc_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = {clr_thread_r, cnt_r[AD_W-1:0]};
                mem_wdata_s = {WIDTH{1'b0}};
                if (cnt_r[AD_W-1:0] == AD_W'(N_REGS - 1)) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {ENTRY_W{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + ENTRY_W'(1);
                end
            end
            default: begin
                state_next_s = ST_INIT;
                cnt_next_s   = {ENTRY_W{1'b0}};
            end
        endcase
    end

    // FSM state, sweep counter, latched clear thread and registered busy.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_INIT;
            cnt_r        <= {ENTRY_W{1'b0}};
            clr_thread_r <= {TH_W{1'b0}};
            busy_r       <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            clr_thread_r <= clr_thread_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    // Block RAM array with a synchronous read into stage 1 (write-first on a same-entry hit).
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
        if (rd_acc_s) begin
            s1_data_r <= fwd_s ? mem_wdata_s : mem[rd_idx_s];
        end
    end

    // Stage-1 valid: a new read reloads it, an output load without reload empties it.
    always_comb begin
        if (rd_acc_s) begin
            s1_valid_next_s = 1'b1;
        end else if (rd_en1) begin
            s1_valid_next_s = 1'b0;
        end else begin
            s1_valid_next_s = s1_valid_r;
        end
    end

    // Stage-1 valid and the separate output register stage.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_next_s;
            if (rd_en1) begin
                dout_r       <= s1_data_r;
                dout_valid_r <= s1_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_registers_bram_mt.sv
// Scoreboard bench for registers_bram_mt: reads push expected {valid,data} into a queue that a
// monitor pops each time the output register loads.
module tb_registers_bram_mt;

    localparam int W  = 16;
    localparam int NT = 16;
    localparam int NR = 16;
    localparam int ND = 4;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic [ND*W-1:0] din;
    logic [1:0]      din_select;
    logic            wr_en;
    logic [3:0]      wr_thread_num;
    logic [3:0]      wr_addr;
    logic            rd_en0;
    logic            rd_en1;
    logic [3:0]      rd_thread_num;
    logic [3:0]      rd_addr;
    logic            clear_req;
    logic [3:0]      clear_thread;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W:0] exp_q[$];

    always #5 CLK = ~CLK;

    registers_bram_mt #(
        .WIDTH(W), .N_THREADS(NT), .N_THREADS_MSB(3), .N_REGS(NR),
        .REG_ADDR_MSB(3), .N_DIN(ND), .SEL_MSB(1)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .din(din), .din_select(din_select),
        .wr_en(wr_en), .wr_thread_num(wr_thread_num), .wr_addr(wr_addr),
        .rd_en0(rd_en0), .rd_en1(rd_en1), .rd_thread_num(rd_thread_num),
        .rd_addr(rd_addr), .clear_req(clear_req), .clear_thread(clear_thread),
        .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        din = '0; din_select = 2'd0; wr_en = 1'b0; wr_thread_num = 4'd0; wr_addr = 4'd0;
        rd_en0 = 1'b0; rd_en1 = 1'b0; rd_thread_num = 4'd0; rd_addr = 4'd0;
        clear_req = 1'b0; clear_thread = 4'd0;
    endtask

    // Distinct background values on every source so a wrong select is visible.
    task automatic set_din(input int sel, input logic [W-1:0] data);
        din = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
        din[sel*W +: W] = data;
        din_select = 2'(sel);
    endtask

    task automatic do_write(input int th, input int ad, input int sel, input logic [W-1:0] data);
        wr_thread_num = 4'(th);
        wr_addr       = 4'(ad);
        set_din(sel, data);
        wr_en = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int th, input int ad, input logic [W:0] exp);
        rd_thread_num = 4'(th);
        rd_addr       = 4'(ad);
        rd_en0        = 1'b1;
        @(negedge CLK);
        rd_en0 = 1'b0;
        rd_en1 = 1'b1;
        exp_q.push_back(exp);
        @(negedge CLK);
        rd_en1 = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            g++;
            @(negedge CLK);
        end
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    // Monitor: whenever the DUT loads its output register, compare against the queue head.
    initial begin : monitor
        bit         en1;
        logic [W:0] e;
        forever begin
            @(posedge CLK);
            en1 = (rd_en1 === 1'b1) && (rst_n === 1'b1);
            #1;
            if (en1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_dout: got %h with nothing expected", {dout_valid, dout});
                end else begin
                    e = exp_q.pop_front();
                    check("read_dout", {dout_valid, dout}, e);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_dout", dout, 16'h0000);
        check("reset_dout_valid", dout_valid, 1'b0);
        check("reset_busy", busy, 1'b1);

        rst_n = 1'b1;
        count_busy(n);
        check("init_busy_cycles", n, 256);
        for (int th = 0; th < NT; th++) begin
            for (int ad = 0; ad < NR; ad++) begin
                do_read(th, ad, {1'b1, 16'h0000});
            end
        end

        do_write(3, 5, 2, 16'hBEEF);
        do_read(3, 5, {1'b1, 16'hBEEF});
        do_write(1, 0, 0, 16'hA0A0);
        do_read(1, 0, {1'b1, 16'hA0A0});
        do_write(15, 15, 3, 16'hF00D);
        do_read(15, 15, {1'b1, 16'hF00D});

        // Same-cycle write and read of (7,9), then an overwrite while stage 1 is pending.
        do_write(7, 9, 1, 16'h0001);
        set_din(1, 16'h1234);
        wr_thread_num = 4'd7; wr_addr = 4'd9; wr_en = 1'b1;
        rd_thread_num = 4'd7; rd_addr = 4'd9; rd_en0 = 1'b1;
        @(negedge CLK);
        rd_en0 = 1'b0;
        set_din(3, 16'h5555);
        rd_en1 = 1'b1;
        exp_q.push_back({1'b1, 16'h1234});
        @(negedge CLK);
        wr_en = 1'b0; rd_en1 = 1'b0;
        do_read(7, 9, {1'b1, 16'h5555});

        // Per-thread clear with activity during busy.
        for (int a = 0; a < NR; a++) begin
            do_write(2, a, a % 4, 16'h2000 + 16'(a));
            do_write(4, a, (a + 1) % 4, 16'h4000 + 16'(a));
        end
        rd_thread_num = 4'd4; rd_addr = 4'd1; rd_en0 = 1'b1;
        @(negedge CLK);
        rd_en0 = 1'b0;
        clear_req = 1'b1; clear_thread = 4'd2;
        @(negedge CLK);
        clear_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            if (n == 2) begin
                wr_thread_num = 4'd4; wr_addr = 4'd3; set_din(0, 16'hDEAD); wr_en = 1'b1;
                rd_thread_num = 4'd4; rd_addr = 4'd2; rd_en0 = 1'b1;
            end
            if (n == 5) begin
                rd_en1 = 1'b1;
                exp_q.push_back({1'b1, 16'h4001});
            end
            if (n == 8) begin
                rd_en1 = 1'b1;
                exp_q.push_back({1'b0, 16'h4001});
            end
            @(negedge CLK);
            wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b0;
        end
        check("clear_busy_cycles", n, 16);
        for (int a = 0; a < NR; a++) begin
            do_read(2, a, {1'b1, 16'h0000});
            do_read(4, a, {1'b1, 16'h4000 + 16'(a)});
        end

        // Clear of thread 6 and a write to thread 5 in the same idle cycle.
        do_write(6, 1, 2, 16'h6001);
        do_write(5, 6, 1, 16'h5006);
        clear_req = 1'b1; clear_thread = 4'd6;
        wr_thread_num = 4'd5; wr_addr = 4'd6; set_din(3, 16'h7777); wr_en = 1'b1;
        @(negedge CLK);
        clear_req = 1'b0; wr_en = 1'b0;
        count_busy(n);
        check("clear_vs_write_busy", n, 16);
        do_read(5, 6, {1'b1, 16'h5006});
        do_read(6, 1, {1'b1, 16'h0000});
        drain();

        // Asynchronous reset, then a second reset at INIT entry 100.
        check("pre_reset_valid", dout_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", dout_valid, 1'b0);
        check("async_reset_dout", dout, 16'h0000);
        check("async_reset_busy", busy, 1'b1);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (100) @(negedge CLK);
        check("mid_init_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_init_reset_valid", dout_valid, 1'b0);
        @(negedge CLK);
        rst_n = 1'b1;
        count_busy(n);
        check("restart_busy_cycles", n, 256);
        do_read(3, 5, {1'b1, 16'h0000});
        do_read(7, 9, {1'b1, 16'h0000});
        do_read(15, 15, {1'b1, 16'h0000});
        do_read(4, 3, {1'b1, 16'h0000});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
